restoring_divider: RTL

//  Sequential unsigned restoring divider computing quotient and remainder of two BUS_WIDTH operands.

---
 rtl/restoring_divider_pkg.sv | 19 +
 rtl/restoring_divider_adder.sv | 25 ++
 rtl/restoring_divider.sv | 117 +++++++++++
 3 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_BUS_WIDTH = 32;

  // Counter must hold values 0..BUS_WIDTH.
  function automatic int unsigned cnt_width(input int unsigned bus_width);
    return $clog2(bus_width + 1);
  endfunction

  localparam int unsigned CNT_WIDTH = cnt_width(DEFAULT_BUS_WIDTH);

endpackage

// File: rtl/restoring_divider_adder.sv
// Ripple-carry adder/subtractor; add_sub_b=1 computes in1 - in2 in two's complement.
module ripple_carry_adder #(
  parameter int unsigned BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] in1,
  input  logic [BUS_WIDTH-1:0] in2,
  input  logic                 add_sub_b,
  output logic [BUS_WIDTH-1:0] out
);

  logic [BUS_WIDTH-1:0] b_eff;
  logic [BUS_WIDTH:0]   carry;

  always_comb begin
    b_eff    = in2 ^ {BUS_WIDTH{add_sub_b}};
    carry    = '0;
    carry[0] = add_sub_b;
    out      = '0;
    for (int i = 0; i < int'(BUS_WIDTH); i++) begin
      out[i]     = in1[i] ^ b_eff[i] ^ carry[i];
      carry[i+1] = (in1[i] & b_eff[i]) | (carry[i] & (in1[i] ^ b_eff[i]));
    end
  end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per cycle, start/done handshake.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] dividend,
  input  logic [BUS_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] quotient,
  output logic [BUS_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  localparam int unsigned CNT_W = cnt_width(BUS_WIDTH);
  localparam int unsigned EXT_W = BUS_WIDTH + 2;

  state_t               state, state_next;
  logic [BUS_WIDTH-1:0] q_reg, r_reg, divisor_reg;
  logic [CNT_W-1:0]     count;
  logic                 accept, last_iter;
  logic [BUS_WIDTH:0]   s;
  logic [EXT_W-1:0]     t;
  logic [BUS_WIDTH-1:0] r_next, q_next;
  logic                 unused_t_bit;

  assign last_iter = (count == CNT_W'(BUS_WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; start is only honoured outside CALC
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (divisor == '0) ? DONE : CALC;
        end else if (state == DONE) begin
          state_next = IDLE;
        end
      end
      CALC:    if (last_iter) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Trial subtraction of the shifted partial remainder
  assign s = {r_reg, q_reg[BUS_WIDTH-1]};

  ripple_carry_adder #(.BUS_WIDTH(EXT_W)) u_sub (
    .in1       ({1'b0, s}),
    .in2       ({2'b00, divisor_reg}),
    .add_sub_b (1'b1),
    .out       (t)
  );

  assign unused_t_bit = t[BUS_WIDTH];

  always_comb begin
    if (!t[EXT_W-1]) begin
      r_next = t[BUS_WIDTH-1:0];
      q_next = {q_reg[BUS_WIDTH-2:0], 1'b1};
    end else begin
      r_next = s[BUS_WIDTH-1:0];
      q_next = {q_reg[BUS_WIDTH-2:0], 1'b0};
    end
  end

  // Datapath and registered outputs; results only move when DONE is entered
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      r_reg       <= '0;
      divisor_reg <= '0;
      count       <= '0;
    end else begin
      busy <= (state_next == CALC);
      done <= (state_next == DONE);
      if (accept) begin
        divisor_reg <= divisor;
        q_reg       <= dividend;
        r_reg       <= '0;
        count       <= '0;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end
      end else if (state == CALC) begin
        q_reg <= q_next;
        r_reg <= r_next;
        count <= count + CNT_W'(1);
        if (last_iter) begin
          quotient    <= q_next;
          remainder   <= r_next;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
